cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 137 +++++++++++++
 tb/tb_cdb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - three-unit result holding slots with round-robin common-data-bus broadcast
//
// Purpose: each execution unit (0 = adder, 1 = multiplier, 2 = load) hands a
// tagged result to its own one-entry holding slot. Every cycle one pending slot
// is granted round-robin and its entry is broadcast on the registered CDB
// outputs at the next edge.
//
// Ports:
//   clk       - rising-edge clock
//   nRST      - asynchronous active-low reset
//   req       - per-unit result-valid request
//   labelIn   - packed per-unit result tags, unit k at [k*LABEL_W +: LABEL_W]
//   dataIn    - packed per-unit result data, unit k at [k*DATA_W +: DATA_W]
//   ready     - per-unit ready; transfer when req[k] & ready[k] at an edge
//   BCEN      - registered broadcast enable
//   BClabel   - registered broadcast tag
//   BCdata    - registered broadcast data
//   pending   - per-unit holding-slot valid
//   bcCount   - saturating count of broadcasts issued
module cdb_arbiter #(
  parameter int LABEL_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic [2:0]           req,
  input  logic [3*LABEL_W-1:0] labelIn,
  input  logic [3*DATA_W-1:0]  dataIn,
  output logic [2:0]           ready,
  output logic                 BCEN,
  output logic [LABEL_W-1:0]   BClabel,
  output logic [DATA_W-1:0]    BCdata,
  output logic [2:0]           pending,
  output logic [15:0]          bcCount
);

  logic [2:0]         slot_valid_q, slot_valid_d;
  logic [LABEL_W-1:0] slot_label_q [3];
  logic [LABEL_W-1:0] slot_label_d [3];
  logic [DATA_W-1:0]  slot_data_q  [3];
  logic [DATA_W-1:0]  slot_data_d  [3];
  logic [1:0]         ptr_q, ptr_d;
  logic               bcen_q, bcen_d;
  logic [LABEL_W-1:0] bclabel_q, bclabel_d;
  logic [DATA_W-1:0]  bcdata_q, bcdata_d;
  logic [15:0]        bc_count_q, bc_count_d;

  logic [1:0] ptr_eff;
  logic [2:0] cand;
  logic [2:0] grant_oh;
  logic [1:0] grant_idx;
  logic       grant_any;
  logic [2:0] accept;

  // Round-robin search starting at ptr; an illegal pointer of 3 starts at 0.
  always_comb begin
    ptr_eff   = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < 3; i++) begin
      cand = {1'b0, ptr_eff} + 3'(i);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!grant_any && slot_valid_q[cand[1:0]]) begin
        grant_any             = 1'b1;
        grant_idx             = cand[1:0];
        grant_oh[cand[1:0]]   = 1'b1;
      end
    end
  end

  // A slot being drained this cycle can accept a new entry at the same edge.
  assign ready = ~slot_valid_q | grant_oh;

  always_comb begin
    slot_valid_d = slot_valid_q;
    for (int k = 0; k < 3; k++) begin
      slot_label_d[k] = slot_label_q[k];
      slot_data_d[k]  = slot_data_q[k];
      // Tag 0 means "no result": the handshake completes but nothing is held.
      accept[k] = req[k] && ready[k] && (labelIn[k*LABEL_W +: LABEL_W] != '0);
      if (accept[k]) begin
        slot_valid_d[k] = 1'b1;
        slot_label_d[k] = labelIn[k*LABEL_W +: LABEL_W];
        slot_data_d[k]  = dataIn[k*DATA_W +: DATA_W];
      end else if (grant_oh[k]) begin
        slot_valid_d[k] = 1'b0;
      end
    end

    bcen_d     = grant_any;
    bclabel_d  = '0;
    bcdata_d   = '0;
    ptr_d      = ptr_eff;
    bc_count_d = bc_count_q;
    if (grant_any) begin
      bclabel_d = slot_label_q[grant_idx];
      bcdata_d  = slot_data_q[grant_idx];
      ptr_d     = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      if (bc_count_q != 16'hFFFF) bc_count_d = bc_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      slot_valid_q <= '0;
      for (int k = 0; k < 3; k++) begin
        slot_label_q[k] <= '0;
        slot_data_q[k]  <= '0;
      end
      ptr_q      <= '0;
      bcen_q     <= 1'b0;
      bclabel_q  <= '0;
      bcdata_q   <= '0;
      bc_count_q <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      for (int k = 0; k < 3; k++) begin
        slot_label_q[k] <= slot_label_d[k];
        slot_data_q[k]  <= slot_data_d[k];
      end
      ptr_q      <= ptr_d;
      bcen_q     <= bcen_d;
      bclabel_q  <= bclabel_d;
      bcdata_q   <= bcdata_d;
      bc_count_q <= bc_count_d;
    end
  end

  assign BCEN    = bcen_q;
  assign BClabel = bclabel_q;
  assign BCdata  = bcdata_q;
  assign pending = slot_valid_q;
  assign bcCount = bc_count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int LW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            nRST;
  logic [2:0]      req;
  logic [3*LW-1:0] labelIn;
  logic [3*DW-1:0] dataIn;
  logic [2:0]      ready;
  logic            BCEN;
  logic [LW-1:0]   BClabel;
  logic [DW-1:0]   BCdata;
  logic [2:0]      pending;
  logic [15:0]     bcCount;

  int n_checks;
  int n_errors;
  int exp_count;

  cdb_arbiter #(.LABEL_W(LW), .DATA_W(DW)) dut (
    .clk(clk), .nRST(nRST), .req(req), .labelIn(labelIn), .dataIn(dataIn),
    .ready(ready), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .pending(pending), .bcCount(bcCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int k, input logic [LW-1:0] l, input logic [DW-1:0] d);
    labelIn[k*LW +: LW] = l;
    dataIn[k*DW +: DW]  = d;
  endtask

  task automatic expect_bc(input string tag, input logic [LW-1:0] l, input logic [DW-1:0] d);
    exp_count++;
    check({tag, ".bcen"}, 64'(BCEN), 64'd1);
    check({tag, ".label"}, 64'(BClabel), 64'(l));
    check({tag, ".data"}, 64'(BCdata), 64'(d));
    check({tag, ".count"}, 64'(bcCount), 64'(exp_count));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".bcen"}, 64'(BCEN), 64'd0);
    check({tag, ".label"}, 64'(BClabel), 64'd0);
    check({tag, ".data"}, 64'(BCdata), 64'd0);
    check({tag, ".count"}, 64'(bcCount), 64'(exp_count));
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    exp_count = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_count = 0;
    nRST    = 1'b0;
    req     = '0;
    labelIn = '0;
    dataIn  = '0;
    #2;
    check("rst.ready", 64'(ready), 64'h7);
    check("rst.pending", 64'(pending), 64'h0);
    expect_idle("rst");
    tick();
    nRST = 1'b1;

    // Single request, one-cycle latency to broadcast.
    req = 3'b001;
    set_unit(0, 5'd3, 32'hA5);
    check("single.ready", 64'(ready), 64'h7);
    tick();
    req = 3'b000;
    check("single.pending", 64'(pending), 64'h1);
    expect_idle("single.lat");
    tick();
    expect_bc("single.bc", 5'd3, 32'hA5);
    check("single.pend_clr", 64'(pending), 64'h0);
    tick();
    expect_idle("single.after");

    // Simultaneous requests from ptr=0.
    do_reset();
    req = 3'b111;
    set_unit(0, 5'd1, 32'hD001);
    set_unit(1, 5'd2, 32'hD002);
    set_unit(2, 5'd3, 32'hD003);
    tick();
    req = 3'b000;
    check("sim.pending", 64'(pending), 64'h7);
    check("sim.ready", 64'(ready), 64'h1);
    tick();
    expect_bc("sim.bc1", 5'd1, 32'hD001);
    tick();
    expect_bc("sim.bc2", 5'd2, 32'hD002);
    tick();
    expect_bc("sim.bc3", 5'd3, 32'hD003);
    tick();
    expect_idle("sim.idle");
    // ptr must be back at 0: unit 0 beats unit 2.
    req = 3'b101;
    set_unit(0, 5'd7, 32'hD007);
    set_unit(2, 5'd8, 32'hD008);
    tick();
    req = 3'b000;
    tick();
    expect_bc("ptr0.first", 5'd7, 32'hD007);
    tick();
    expect_bc("ptr0.second", 5'd8, 32'hD008);
    tick();

    // Rotation: move ptr to 1, then units 0 and 2 pending -> unit 2 first.
    req = 3'b001;
    set_unit(0, 5'd9, 32'hD009);
    tick();
    req = 3'b000;
    tick();
    expect_bc("rot.setup", 5'd9, 32'hD009);
    req = 3'b101;
    set_unit(0, 5'd10, 32'hD010);
    set_unit(2, 5'd11, 32'hD011);
    tick();
    req = 3'b000;
    tick();
    expect_bc("rot.first", 5'd11, 32'hD011);
    tick();
    expect_bc("rot.second", 5'd10, 32'hD010);
    tick();
    expect_idle("rot.idle");

    // Back-to-back on unit 1, tags 4..7.
    req = 3'b010;
    for (int i = 0; i < 4; i++) begin
      set_unit(1, LW'(4 + i), DW'(32'hB000 + i));
      check($sformatf("b2b.ready%0d", i), 64'(ready[1]), 64'd1);
      tick();
      if (i > 0) expect_bc($sformatf("b2b.bc%0d", i), LW'(3 + i), DW'(32'hB000 + i - 1));
    end
    req = 3'b000;
    tick();
    expect_bc("b2b.bc4", 5'd7, 32'hB003);
    tick();
    expect_idle("b2b.idle");

    // Tag zero is dropped.
    req = 3'b001;
    set_unit(0, 5'd0, 32'hDEAD);
    tick();
    req = 3'b000;
    check("tag0.pending", 64'(pending), 64'h0);
    tick();
    expect_idle("tag0.idle");

    // Reset mid-run with two slots pending.
    req = 3'b011;
    set_unit(0, 5'd12, 32'hD012);
    set_unit(1, 5'd13, 32'hD013);
    tick();
    req = 3'b000;
    check("mid.pending", 64'(pending), 64'h3);
    #2;
    nRST = 1'b0;
    #1;
    exp_count = 0;
    check("mid.rst_pending", 64'(pending), 64'h0);
    check("mid.rst_ready", 64'(ready), 64'h7);
    expect_idle("mid.rst");
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_idle($sformatf("mid.post%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
